moesi_snoop_responder: RTL and testbench

Per-core snoop responder: the receiving end of the coherency bus broadcast. It captures each broadcast transaction from another core and looks up the line in the local core's MOESI tag array. It then drives that core's snoop response bit, writes back the next MOESI state, and requests a data flush when the local copy is dirty-owned. One instance sits between the coherency bus and each core's L1 tag/state array.

---
 rtl/moesi_snoop_responder.sv | 198 +++++++++++++++++++
 tb/tb_moesi_snoop_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/moesi_snoop_responder.sv
// rtl/moesi_snoop_responder.sv - per-core MOESI snoop responder between coherency bus and L1 tag/state array
// One broadcast is handled at a time: capture, tag lookup, respond/update, optional dirty-line flush.

module moesi_snoop_responder #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int CORE_ID    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         bus_valid,
    input  logic [ADDR_WIDTH-1:0]        bus_addr,
    input  logic [1:0]                   bus_type,
    input  logic [$clog2(NUM_CORES)-1:0] granted_core_id,
    output logic                         snoop_resp,
    output logic                         snoop_done,
    output logic                         tag_rd_en,
    output logic [ADDR_WIDTH-1:0]        tag_rd_addr,
    input  logic                         tag_rd_hit,
    input  logic [2:0]                   tag_rd_state,
    output logic                         tag_wr_en,
    output logic [ADDR_WIDTH-1:0]        tag_wr_addr,
    output logic [2:0]                   tag_wr_state,
    output logic                         flush_req,
    output logic [ADDR_WIDTH-1:0]        flush_addr,
    input  logic                         flush_ack,
    output logic                         busy,
    output logic                         snoop_overrun,
    output logic                         proto_err
);

    localparam int ID_W = $clog2(NUM_CORES);

    localparam logic [1:0] BUS_RD   = 2'd0;
    localparam logic [1:0] BUS_RDX  = 2'd1;
    localparam logic [1:0] BUS_UPGR = 2'd2;
    localparam logic [1:0] BUS_WB   = 2'd3;

    localparam logic [2:0] ST_I = 3'd0;
    localparam logic [2:0] ST_S = 3'd1;
    localparam logic [2:0] ST_E = 3'd2;
    localparam logic [2:0] ST_O = 3'd3;
    localparam logic [2:0] ST_M = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        RESPOND = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            type_q, type_d;
    logic                  tag_rd_en_q, tag_rd_en_d;
    logic [ADDR_WIDTH-1:0] tag_rd_addr_q, tag_rd_addr_d;
    logic                  flush_req_q, flush_req_d;
    logic [ADDR_WIDTH-1:0] flush_addr_q, flush_addr_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;
    logic                  proto_q, proto_d;

    logic       foreign_snoop;
    logic       valid_hit;
    logic       bad_state;
    logic [2:0] cur_state;
    logic [2:0] nxt_state;
    logic       need_flush;
    logic       upgr_err;
    logic       in_respond;

    // Snoops from other cores that can change our copy; writebacks never do.
    assign foreign_snoop = bus_valid && (granted_core_id != ID_W'(CORE_ID)) && (bus_type != BUS_WB);

    always_comb begin
        valid_hit  = tag_rd_hit && (tag_rd_state != ST_I) && (tag_rd_state <= ST_M);
        bad_state  = tag_rd_hit && (tag_rd_state > ST_M);
        cur_state  = valid_hit ? tag_rd_state : ST_I;
        nxt_state  = cur_state;
        need_flush = 1'b0;
        upgr_err   = 1'b0;
        case (type_q)
            BUS_RD: begin
                case (cur_state)
                    ST_M: begin
                        nxt_state  = ST_O;
                        need_flush = 1'b1;
                    end
                    ST_O: need_flush = 1'b1;
                    ST_E: nxt_state = ST_S;
                    default: nxt_state = cur_state;
                endcase
            end
            BUS_RDX: begin
                nxt_state  = ST_I;
                need_flush = (cur_state == ST_M) || (cur_state == ST_O);
            end
            BUS_UPGR: begin
                // An upgrade from another core means it believed it shared the line,
                // so an exclusive copy here is a coherence violation.
                nxt_state = ST_I;
                upgr_err  = (cur_state == ST_M) || (cur_state == ST_E);
            end
            default: nxt_state = cur_state;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        type_d        = type_q;
        tag_rd_en_d   = 1'b0;
        tag_rd_addr_d = '0;
        flush_req_d   = flush_req_q;
        flush_addr_d  = flush_addr_q;
        overrun_d     = overrun_q;
        proto_d       = proto_q;
        case (state_q)
            IDLE: begin
                if (foreign_snoop) begin
                    addr_d        = bus_addr;
                    type_d        = bus_type;
                    state_d       = LOOKUP;
                    tag_rd_en_d   = 1'b1;
                    tag_rd_addr_d = bus_addr;
                end
            end
            LOOKUP: state_d = RESPOND;
            RESPOND: begin
                if (bad_state || upgr_err) begin
                    proto_d = 1'b1;
                end
                if (need_flush) begin
                    state_d      = FLUSH;
                    flush_req_d  = 1'b1;
                    flush_addr_d = addr_q;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (flush_ack && flush_req_q) begin
                    state_d      = IDLE;
                    flush_req_d  = 1'b0;
                    flush_addr_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (foreign_snoop && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            type_q        <= 2'd0;
            tag_rd_en_q   <= 1'b0;
            tag_rd_addr_q <= '0;
            flush_req_q   <= 1'b0;
            flush_addr_q  <= '0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            proto_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            type_q        <= type_d;
            tag_rd_en_q   <= tag_rd_en_d;
            tag_rd_addr_q <= tag_rd_addr_d;
            flush_req_q   <= flush_req_d;
            flush_addr_q  <= flush_addr_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            proto_q       <= proto_d;
        end
    end

    // Tag data only arrives in RESPOND, so the response/update strobes decode it directly.
    assign in_respond    = (state_q == RESPOND);
    assign snoop_done    = in_respond;
    assign snoop_resp    = in_respond && valid_hit;
    assign tag_wr_en     = in_respond && (nxt_state != cur_state);
    assign tag_wr_state  = tag_wr_en ? nxt_state : ST_I;
    assign tag_wr_addr   = tag_wr_en ? addr_q : '0;

    assign tag_rd_en     = tag_rd_en_q;
    assign tag_rd_addr   = tag_rd_addr_q;
    assign flush_req     = flush_req_q;
    assign flush_addr    = flush_addr_q;
    assign busy          = busy_q;
    assign snoop_overrun = overrun_q;
    assign proto_err     = proto_q;

endmodule

// File: tb/tb_moesi_snoop_responder.sv
// tb/tb_moesi_snoop_responder.sv - self-checking bench for moesi_snoop_responder
// Vector table, random snoops against a table-driven MOESI model, and hand-written corner sequences.

module tb_moesi_snoop_responder;

    logic        clk;
    logic        rst;
    logic        bus_valid;
    logic [63:0] bus_addr;
    logic [1:0]  bus_type;
    logic [1:0]  granted_core_id;
    logic        snoop_resp;
    logic        snoop_done;
    logic        tag_rd_en;
    logic [63:0] tag_rd_addr;
    logic        tag_rd_hit;
    logic [2:0]  tag_rd_state;
    logic        tag_wr_en;
    logic [63:0] tag_wr_addr;
    logic [2:0]  tag_wr_state;
    logic        flush_req;
    logic [63:0] flush_addr;
    logic        flush_ack;
    logic        busy;
    logic        snoop_overrun;
    logic        proto_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_proto = 1'b0;

    moesi_snoop_responder #(.NUM_CORES(4), .ADDR_WIDTH(64), .CORE_ID(0)) dut (
        .clk(clk), .rst(rst),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_type(bus_type),
        .granted_core_id(granted_core_id),
        .snoop_resp(snoop_resp), .snoop_done(snoop_done),
        .tag_rd_en(tag_rd_en), .tag_rd_addr(tag_rd_addr),
        .tag_rd_hit(tag_rd_hit), .tag_rd_state(tag_rd_state),
        .tag_wr_en(tag_wr_en), .tag_wr_addr(tag_wr_addr), .tag_wr_state(tag_wr_state),
        .flush_req(flush_req), .flush_addr(flush_addr), .flush_ack(flush_ack),
        .busy(busy), .snoop_overrun(snoop_overrun), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [1:0] typ;
        logic [1:0] gid;
        logic       hit;
        logic [2:0] st;
        int         dly;
        logic       resp;
        logic       wr;
        logic [2:0] ws;
        logic       fl;
        logic       pe;
    } vec_t;

    vec_t tbl[10];

    // Model tables indexed [bus_type][current MOESI state I,S,E,O,M].
    logic [2:0] m_next [3][5] = '{'{3'd0, 3'd1, 3'd1, 3'd3, 3'd3},
                                  '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                                  '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
    logic       m_flush [3][5] = '{'{1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
                                   '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
                                   '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    logic       m_err   [3][5] = '{'{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
                                   '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
                                   '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1}};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input logic [1:0] typ, input logic hit, input logic [2:0] st,
                         output logic resp, output logic wr, output logic [2:0] ws,
                         output logic fl, output logic pe);
        int cur;
        logic bad;
        bad  = hit && (st > 3'd4);
        cur  = (hit && !bad) ? int'(st) : 0;
        resp = (cur != 0);
        ws   = m_next[typ][cur];
        wr   = (int'(ws) != cur);
        fl   = m_flush[typ][cur];
        pe   = bad || m_err[typ][cur];
    endtask

    task automatic run_snoop(input logic [1:0] typ, input logic [1:0] gid, input logic [63:0] addr,
                             input logic hit, input logic [2:0] st, input int dly,
                             input logic resp, input logic wr, input logic [2:0] ws, input logic fl);
        bus_valid       = 1'b1;
        bus_type        = typ;
        granted_core_id = gid;
        bus_addr        = addr;
        tick();
        bus_valid = 1'b0;
        bus_addr  = 64'($urandom);
        check("tag_rd_en", tag_rd_en, 1);
        check("tag_rd_addr", tag_rd_addr, addr);
        check("busy_lookup", busy, 1);
        tick();
        tag_rd_hit   = hit;
        tag_rd_state = st;
        #1;
        check("snoop_done", snoop_done, 1);
        check("snoop_resp", snoop_resp, resp);
        check("tag_wr_en", tag_wr_en, wr);
        if (wr) begin
            check("tag_wr_state", tag_wr_state, ws);
            check("tag_wr_addr", tag_wr_addr, addr);
        end
        tick();
        tag_rd_hit   = 1'b0;
        tag_rd_state = 3'($urandom);
        check("flush_req", flush_req, fl);
        check("proto_err", proto_err, exp_proto);
        check("snoop_done_off", snoop_done, 0);
        if (fl) begin
            check("busy_flush", busy, 1);
            check("flush_addr", flush_addr, addr);
            for (int k = 0; k < dly; k++) begin
                tick();
                check("flush_req_hold", flush_req, 1);
            end
            flush_ack = 1'b1;
            tick();
            flush_ack = 1'b0;
            check("flush_req_after_ack", flush_req, 0);
            check("busy_after_ack", busy, 0);
        end else begin
            check("busy_done", busy, 0);
        end
    endtask

    initial begin
        logic r_resp, r_wr, r_fl, r_pe;
        logic [2:0] r_ws, r_st;
        logic [1:0] r_typ, r_gid;
        logic r_hit;
        logic [63:0] addr_a, addr_b;

        tbl[0] = '{2'd0, 2'd1, 1'b1, 3'd4, 2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0};
        tbl[1] = '{2'd1, 2'd2, 1'b1, 3'd1, 0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[2] = '{2'd0, 2'd3, 1'b0, 3'd4, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[3] = '{2'd2, 2'd1, 1'b1, 3'd2, 0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1};
        tbl[4] = '{2'd0, 2'd2, 1'b1, 3'd3, 0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[5] = '{2'd0, 2'd3, 1'b1, 3'd2, 0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[6] = '{2'd1, 2'd1, 1'b1, 3'd4, 1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0};
        tbl[7] = '{2'd2, 2'd2, 1'b1, 3'd1, 0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[8] = '{2'd0, 2'd3, 1'b1, 3'd6, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[9] = '{2'd1, 2'd1, 1'b1, 3'd0, 0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};

        rst = 1'b1;
        bus_valid = 1'b0; bus_addr = '0; bus_type = '0; granted_core_id = '0;
        tag_rd_hit = 1'b0; tag_rd_state = '0; flush_ack = 1'b0;

        // Outputs held at zero under reset regardless of input activity.
        for (int i = 0; i < 4; i++) begin
            bus_valid       = 1'($urandom);
            bus_addr        = {$urandom, $urandom};
            bus_type        = 2'($urandom);
            granted_core_id = 2'($urandom);
            tag_rd_hit      = 1'($urandom);
            tag_rd_state    = 3'($urandom);
            flush_ack       = 1'($urandom);
            tick();
            check("reset_outputs",
                  {snoop_resp, snoop_done, tag_rd_en, tag_wr_en, tag_wr_state, flush_req,
                   busy, snoop_overrun, proto_err} | {59'd0, |tag_rd_addr, |tag_wr_addr, |flush_addr},
                  0);
        end
        bus_valid = 1'b0; tag_rd_hit = 1'b0; flush_ack = 1'b0;
        rst = 1'b0;
        tick();
        check("busy_after_reset", busy, 0);

        // Self-originated and writeback broadcasts are ignored.
        for (int i = 0; i < 2; i++) begin
            bus_valid       = 1'b1;
            bus_type        = (i == 0) ? 2'd0 : 2'd3;
            granted_core_id = (i == 0) ? 2'd0 : 2'd2;
            bus_addr        = {$urandom, $urandom};
            tick();
            bus_valid = 1'b0;
            check("ignored_tag_rd_en", tag_rd_en, 0);
            check("ignored_busy", busy, 0);
            tick();
            check("ignored_snoop_done", snoop_done, 0);
            check("ignored_overrun", snoop_overrun, 0);
        end

        for (int i = 0; i < 10; i++) begin
            exp_proto = exp_proto | tbl[i].pe;
            run_snoop(tbl[i].typ, tbl[i].gid, {$urandom, $urandom}, tbl[i].hit, tbl[i].st,
                      tbl[i].dly, tbl[i].resp, tbl[i].wr, tbl[i].ws, tbl[i].fl);
        end

        for (int i = 0; i < 60; i++) begin
            r_typ = 2'($urandom_range(0, 2));
            r_gid = 2'($urandom_range(1, 3));
            r_hit = 1'($urandom);
            r_st  = 3'($urandom_range(0, 7));
            model(r_typ, r_hit, r_st, r_resp, r_wr, r_ws, r_fl, r_pe);
            exp_proto = exp_proto | r_pe;
            run_snoop(r_typ, r_gid, {$urandom, $urandom}, r_hit, r_st,
                      $urandom_range(0, 3), r_resp, r_wr, r_ws, r_fl);
        end
        check("overrun_clear_after_spaced_traffic", snoop_overrun, 0);

        // Overrun during FLUSH, then reset mid-flush.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        addr_a = {$urandom, $urandom};
        addr_b = ~addr_a;
        bus_valid = 1'b1; bus_type = 2'd0; granted_core_id = 2'd1; bus_addr = addr_a;
        tick();
        bus_valid = 1'b0;
        tick();
        tag_rd_hit = 1'b1; tag_rd_state = 3'd4;
        tick();
        tag_rd_hit = 1'b0;
        check("ovr_flush_req", flush_req, 1);
        bus_valid = 1'b1; bus_type = 2'd1; granted_core_id = 2'd2; bus_addr = addr_b;
        tick();
        bus_valid = 1'b0;
        check("ovr_sticky", snoop_overrun, 1);
        check("ovr_flush_addr", flush_addr, addr_a);
        check("ovr_flush_req_held", flush_req, 1);
        check("ovr_no_new_lookup", tag_rd_en, 0);
        rst = 1'b1;
        #1;
        check("rst_flush_req", flush_req, 0);
        check("rst_overrun", snoop_overrun, 0);
        check("rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();

        // Broadcast in the RESPOND cycle counts as overrun and is not accepted.
        bus_valid = 1'b1; bus_type = 2'd0; granted_core_id = 2'd3; bus_addr = addr_a;
        tick();
        bus_valid = 1'b0;
        tick();
        tag_rd_hit = 1'b1; tag_rd_state = 3'd1;
        bus_valid = 1'b1; bus_type = 2'd1; granted_core_id = 2'd2; bus_addr = addr_b;
        #1;
        check("respond_shared_no_write", tag_wr_en, 0);
        check("respond_shared_resp", snoop_resp, 1);
        tick();
        bus_valid = 1'b0; tag_rd_hit = 1'b0;
        check("respond_overrun", snoop_overrun, 1);
        check("respond_busy", busy, 0);
        check("respond_not_accepted", tag_rd_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
